// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply array and its result drain.
// Both ends derive the sum width from here so they always agree on it.
package mm_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

    function automatic int c_width(input int data_width, input int n);
        return 2 * data_width + $clog2(n);
    endfunction

endpackage

// File: rtl/mm_drain_buffer.sv
// Snapshot register file for N*N sums. It loads all sums in parallel and
// presents one row (or one column when TRANSPOSE is set) of N sums, selected by idx.
module mm_drain_buffer
    import mm_pkg::*;
#(
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = 18,
    parameter int TRANSPOSE    = 0,
    parameter int IDX_W        = 2
) (
    input  logic                            clk,
    input  logic                            reset_ni,
    input  logic                            load,
    input  logic [N*N*C_DATA_WIDTH-1:0]     sums,
    input  logic [IDX_W-1:0]                idx,
    output logic [N*C_DATA_WIDTH-1:0]       beat
);

    localparam int AW = ($clog2(N * N) > 0) ? $clog2(N * N) : 1;

    logic [C_DATA_WIDTH-1:0] mem_r [N*N];

    for (genvar g = 0; g < N * N; g++) begin : g_cell
        // Each cell clears on reset and captures its sum on a load.
        always_ff @(posedge clk) begin
            if (!reset_ni) begin
                mem_r[g] <= '0;
            end else if (load) begin
                mem_r[g] <= sums[g*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [AW-1:0] addr_s;
        // Lane g reads column g of the selected row, or row g of the selected column.
        if (TRANSPOSE != 0) begin : g_col
            assign addr_s = AW'(g * N) + AW'(idx);
        end else begin : g_row
            assign addr_s = AW'(idx) * AW'(N) + AW'(g);
        end
        assign beat[g*C_DATA_WIDTH +: C_DATA_WIDTH] = mem_r[addr_s];
    end

endmodule

// File: rtl/mm_result_drain.sv
// Result drain for the sum-stationary array: snapshots all sums in one cycle,
// pulses a clear back into the array, then streams N beats under valid/ready.
module mm_result_drain
    import mm_pkg::*;
#(
    parameter int  DATA_WIDTH   = 8,
    parameter int  N            = 4,
    parameter int  C_DATA_WIDTH = c_width(DATA_WIDTH, N),
    parameter int  TRANSPOSE    = 0,
    localparam int IDX_W        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                         clk,
    input  logic                         reset_ni,
    input  logic                         array_valid_i,
    input  logic [N*N*C_DATA_WIDTH-1:0]  array_c_i,
    output logic                         array_clear_o,
    output logic [N*C_DATA_WIDTH-1:0]    beat_o,
    output logic                         beat_valid_o,
    input  logic                         beat_ready_i,
    output logic [IDX_W-1:0]             beat_idx_o,
    output logic                         beat_last_o,
    output logic                         busy_o
);

    localparam logic [0:0]       ST_IDLE   = IDLE;
    localparam logic [0:0]       ST_STREAM = STREAM;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

    logic [0:0]       state_r;
    logic [IDX_W-1:0] idx_r;
    logic             clear_r;
    logic             load_s;

    // The array keeps valid_o high until cleared, so only sample it when idle
    // and not in the cycle the clear is still travelling back to it.
    assign load_s = (state_r == ST_IDLE) && array_valid_i && !clear_r;

    // Drain FSM, beat counter and clear pulse.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            clear_r <= 1'b0;
        end else begin
            clear_r <= load_s;
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r <= ST_STREAM;
                        idx_r   <= '0;
                    end
                end
                ST_STREAM: begin
                    if (beat_ready_i) begin
                        if (idx_r == LAST_IDX) begin
                            state_r <= ST_IDLE;
                            idx_r   <= '0;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= '0;
                end
            endcase
        end
    end

    mm_drain_buffer #(
        .N            (N),
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .TRANSPOSE    (TRANSPOSE),
        .IDX_W        (IDX_W)
    ) u_buffer (
        .clk      (clk),
        .reset_ni (reset_ni),
        .load     (load_s),
        .sums     (array_c_i),
        .idx      (idx_r),
        .beat     (beat_o)
    );

    assign array_clear_o = clear_r;
    assign beat_valid_o  = (state_r == ST_STREAM);
    assign busy_o        = (state_r == ST_STREAM);
    assign beat_idx_o    = idx_r;
    assign beat_last_o   = (state_r == ST_STREAM) && (idx_r == LAST_IDX);

endmodule

// File: tb/tb_mm_result_drain.sv
// Scoreboard bench for mm_result_drain: a row-order and a column-order instance
// share the same stimulus; expected beats are queued at capture and popped by monitors.
module tb_mm_result_drain;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 18;
    localparam int BW = N * CW;
    localparam int MW = N * N * CW;

    typedef struct packed {
        logic [BW-1:0] beat;
        logic [1:0]    idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic          array_valid_i;
    logic          beat_ready_i;
    logic [MW-1:0] array_c_i;

    logic          row_clear, row_valid, row_last, row_busy;
    logic [BW-1:0] row_beat;
    logic [1:0]    row_idx;
    logic          col_clear, col_valid, col_last, col_busy;
    logic [BW-1:0] col_beat;
    logic [1:0]    col_idx;

    exp_t row_q[$];
    exp_t col_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mm_result_drain #(.DATA_WIDTH(DW), .N(N), .C_DATA_WIDTH(CW), .TRANSPOSE(0)) dut_row (
        .clk(clk), .reset_ni(reset_ni), .array_valid_i(array_valid_i), .array_c_i(array_c_i),
        .array_clear_o(row_clear), .beat_o(row_beat), .beat_valid_o(row_valid),
        .beat_ready_i(beat_ready_i), .beat_idx_o(row_idx), .beat_last_o(row_last), .busy_o(row_busy)
    );

    mm_result_drain #(.DATA_WIDTH(DW), .N(N), .C_DATA_WIDTH(CW), .TRANSPOSE(1)) dut_col (
        .clk(clk), .reset_ni(reset_ni), .array_valid_i(array_valid_i), .array_c_i(array_c_i),
        .array_clear_o(col_clear), .beat_o(col_beat), .beat_valid_o(col_valid),
        .beat_ready_i(beat_ready_i), .beat_idx_o(col_idx), .beat_last_o(col_last), .busy_o(col_busy)
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] mat(input int base);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[(i*N+j)*CW +: CW] = CW'(base + 4*i + j);
        return m;
    endfunction

    function automatic logic [BW-1:0] exp_beat(input int base, input int k, input bit tr);
        logic [BW-1:0] b;
        b = '0;
        for (int j = 0; j < N; j++)
            b[j*CW +: CW] = tr ? CW'(base + 4*j + k) : CW'(base + 4*k + j);
        return b;
    endfunction

    task automatic push_matrix(input int base);
        for (int k = 0; k < N; k++) begin
            row_q.push_back('{beat: exp_beat(base, k, 1'b0), idx: 2'(k)});
            col_q.push_back('{beat: exp_beat(base, k, 1'b1), idx: 2'(k)});
        end
    endtask

    task automatic mon_cmp(input string who, input exp_t e, input logic [BW-1:0] beat,
                           input logic [1:0] idx, input logic last);
        check({who, "_beat"}, beat, e.beat);
        check({who, "_idx"}, BW'(idx), BW'(e.idx));
        check({who, "_last"}, BW'(last), BW'(e.idx == 2'd3));
    endtask

    // Row-order monitor: compare on every valid cycle, pop on transfer.
    always @(negedge clk) begin
        if (reset_ni && row_valid) begin
            if (row_q.size() == 0) begin
                check("row_unexpected_beat", BW'(row_valid), BW'(0));
            end else begin
                mon_cmp("row", row_q[0], row_beat, row_idx, row_last);
                if (beat_ready_i) void'(row_q.pop_front());
            end
        end
    end

    // Column-order monitor.
    always @(negedge clk) begin
        if (reset_ni && col_valid) begin
            if (col_q.size() == 0) begin
                check("col_unexpected_beat", BW'(col_valid), BW'(0));
            end else begin
                mon_cmp("col", col_q[0], col_beat, col_idx, col_last);
                if (beat_ready_i) void'(col_q.pop_front());
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_row_valid"}, BW'(row_valid), BW'(0));
        check({tag, "_row_busy"},  BW'(row_busy),  BW'(0));
        check({tag, "_row_clear"}, BW'(row_clear), BW'(0));
        check({tag, "_row_last"},  BW'(row_last),  BW'(0));
        check({tag, "_row_idx"},   BW'(row_idx),   BW'(0));
        check({tag, "_col_valid"}, BW'(col_valid), BW'(0));
        check({tag, "_col_busy"},  BW'(col_busy),  BW'(0));
        check({tag, "_col_clear"}, BW'(col_clear), BW'(0));
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_row_q_empty"}, BW'(row_q.size()), BW'(0));
        check({tag, "_col_q_empty"}, BW'(col_q.size()), BW'(0));
    endtask

    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        // 1: reset, then idle indefinitely without array_valid_i
        reset_ni      = 1'b0;
        array_valid_i = 1'b0;
        beat_ready_i  = 1'b0;
        array_c_i     = mat(100);
        step(3);
        reset_ni = 1'b1;
        step(1);
        check_idle("reset");
        check("reset_row_beat", row_beat, BW'(0));
        check("reset_col_beat", col_beat, BW'(0));
        step(5);
        check_idle("idle_hold");

        // 2/3: single capture with ready high; row and column order
        push_matrix(100);
        array_valid_i = 1'b1;
        beat_ready_i  = 1'b1;
        step(1);
        check("t2_clear_hi_row", BW'(row_clear), BW'(1));
        check("t2_clear_hi_col", BW'(col_clear), BW'(1));
        check("t2_busy", BW'(row_busy), BW'(1));
        array_valid_i = 1'b0;
        step(1);
        check("t2_clear_lo", BW'(row_clear), BW'(0));
        check("t2_valid_b1", BW'(row_valid), BW'(1));
        step(2);
        check("t2_last", BW'(row_last), BW'(1));
        step(1);
        check("t2_busy_drop", BW'(row_busy), BW'(0));
        check_drained("t2");

        // 4: back-pressure pattern, stable data through stalls
        array_c_i = mat(300);
        push_matrix(300);
        array_valid_i = 1'b1;
        beat_ready_i  = 1'b0;
        step(1);
        array_valid_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            beat_ready_i = (pat[i] != 0);
            step(1);
        end
        beat_ready_i = 1'b1;
        check("t4_busy_done", BW'(row_busy), BW'(0));
        check_drained("t4");

        // 5: valid held high with new data on the bus during streaming
        array_c_i = mat(100);
        push_matrix(100);
        push_matrix(200);
        array_valid_i = 1'b1;
        step(1);
        array_c_i = mat(200);
        check("t5_clear1", BW'(row_clear), BW'(1));
        step(4);
        check("t5_idle_gap", BW'(row_busy), BW'(0));
        step(1);
        check("t5_clear2", BW'(row_clear), BW'(1));
        check("t5_idx0", BW'(row_idx), BW'(0));
        array_valid_i = 1'b0;
        step(4);
        check("t5_busy_done", BW'(col_busy), BW'(0));
        check_drained("t5");

        // 6: reset after beat 1 transfers, then a fresh capture
        array_c_i = mat(400);
        push_matrix(400);
        array_valid_i = 1'b1;
        step(1);
        array_valid_i = 1'b0;
        step(2);
        reset_ni = 1'b0;
        row_q.delete();
        col_q.delete();
        step(1);
        check_idle("t6_reset");
        check("t6_row_beat_zero", row_beat, BW'(0));
        reset_ni = 1'b1;
        step(3);
        check_idle("t6_quiet");
        array_c_i = mat(500);
        push_matrix(500);
        array_valid_i = 1'b1;
        step(1);
        check("t6_restart_valid", BW'(row_valid), BW'(1));
        check("t6_restart_idx", BW'(row_idx), BW'(0));
        array_valid_i = 1'b0;
        step(4);
        check("t6_busy_done", BW'(row_busy), BW'(0));
        check_drained("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
